// File: rtl/comparator_32bit_signed_gteq_serial.sv
// Bit-serial signed comparator: scans a and b LSB-first, STEP bits per cycle, and reports ge = (a >= b).
// Optional eq output (a == b) is enabled by defining COMPARATOR_SERIAL_EQ_OUT_EN.
module comparator_32bit_signed_gteq_serial #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ge
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
    ,
    output logic             eq
`endif
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic             ge_acc_reg;
    logic             ge_next;
    logic             last_group;
    logic [STEP:0]    ge_chain;

    assign last_group  = (cnt_reg == LAST);
    assign ge_chain[0] = ge_acc_reg;
    assign ge_next     = ge_chain[STEP];

`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
    logic          eq_acc_reg;
    logic          eq_next;
    logic [STEP:0] eq_chain;

    assign eq_chain[0] = eq_acc_reg;
    assign eq_next     = eq_chain[STEP];
`endif

    // Higher bits later in the chain override lower ones, so the most significant
    // differing bit decides. At the sign bit a 1 means negative, hence b wins.
    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_bit
            logic diff;
            logic sign_bit;
            assign diff           = a_sh_reg[gi] ^ b_sh_reg[gi];
            assign sign_bit       = last_group && (gi == STEP - 1);
            assign ge_chain[gi+1] = diff ? (sign_bit ? b_sh_reg[gi] : a_sh_reg[gi])
                                         : ge_chain[gi];
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
            assign eq_chain[gi+1] = eq_chain[gi] & ~diff;
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            ge         <= 1'b0;
            cnt_reg    <= '0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            ge_acc_reg <= 1'b0;
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
            eq         <= 1'b0;
            eq_acc_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh_reg   <= a;
                        b_sh_reg   <= b;
                        ge_acc_reg <= 1'b1;
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
                        eq_acc_reg <= 1'b1;
`endif
                        cnt_reg    <= '0;
                        in_ready   <= 1'b0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg   <= a_sh_reg >> STEP;
                    b_sh_reg   <= b_sh_reg >> STEP;
                    ge_acc_reg <= ge_next;
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
                    eq_acc_reg <= eq_next;
`endif
                    if (last_group) begin
                        ge        <= ge_next;
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
                        eq        <= eq_next;
`endif
                        out_valid <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    // Results stay on ge/eq after the handshake until the next DONE entry.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_32bit_signed_gteq_serial.sv
// Self-checking bench for the bit-serial signed >= comparator (STEP=1 and STEP=4 instances).
module tb_comparator_32bit_signed_gteq_serial;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv1, ir1, ov1, or1, ge1;
    logic [31:0] a1, b1;
    logic        iv4, ir4, ov4, or4, ge4;
    logic [31:0] a4, b4;
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
    logic        eq1, eq4;
`endif

    comparator_32bit_signed_gteq_serial #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .ge(ge1)
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
        , .eq(eq1)
`endif
    );

    comparator_32bit_signed_gteq_serial #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .ge(ge4)
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
        , .eq(eq4)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic ge;
        logic eq;
    } exp_t;
    exp_t q1[$];
    exp_t q4[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ge;
        logic        eq;
        string       name;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic wait_out1(output int lat);
        lat = 0;
        while (!ov1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_out4(output int lat);
        lat = 0;
        while (!ov4 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic pop_cmp1(input string nm);
        exp_t e;
        checks++;
        if (q1.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard actual=empty required=entry", nm);
            return;
        end
        e = q1.pop_front();
        chk({nm, "_ge"}, {31'd0, ge1}, {31'd0, e.ge});
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
        chk({nm, "_eq"}, {31'd0, eq1}, {31'd0, e.eq});
`endif
    endtask

    task automatic pop_cmp4(input string nm);
        exp_t e;
        checks++;
        if (q4.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard actual=empty required=entry", nm);
            return;
        end
        e = q4.pop_front();
        chk({nm, "_ge"}, {31'd0, ge4}, {31'd0, e.ge});
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
        chk({nm, "_eq"}, {31'd0, eq4}, {31'd0, e.eq});
`endif
    endtask

    // Entered #1 after a rising edge with the STEP=1 instance idle.
    task automatic xact1(input logic [31:0] av, input logic [31:0] bv,
                         input logic eg, input logic ee, input string nm);
        int   lat;
        exp_t e;
        chk({nm, "_in_ready"}, {31'd0, ir1}, 32'd1);
        a1 = av; b1 = bv; iv1 = 1'b1; or1 = 1'b1;
        @(posedge clk);
        e.ge = eg; e.eq = ee;
        q1.push_back(e);
        #1;
        iv1 = 1'b0; a1 = ~av; b1 = bv ^ 32'h5555_5555;
        wait_out1(lat);
        chk({nm, "_latency"}, lat, 32'd32);
        $display("xact %s a=%h b=%h ge=%b latency=%0d", nm, av, bv, ge1, lat);
        pop_cmp1(nm);
        @(posedge clk); #1;
        chk({nm, "_out_valid_drop"}, {31'd0, ov1}, 32'd0);
    endtask

    initial begin
        int   lat;
        exp_t e;
        logic [31:0] av, bv;

        vecs[0] = '{32'd5,          32'd5,          1'b1, 1'b1, "eq5"};
        vecs[1] = '{32'hFFFF_FFFF,  32'h0000_0000,  1'b0, 1'b0, "m1_vs_0"};
        vecs[2] = '{32'h0000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, "0_vs_m1"};
        vecs[3] = '{32'h7FFF_FFFF,  32'h8000_0000,  1'b1, 1'b0, "max_vs_min"};
        vecs[4] = '{32'h8000_0000,  32'h8000_0001,  1'b0, 1'b0, "min_vs_minp1"};
        vecs[5] = '{32'h8000_0000,  32'h8000_0000,  1'b1, 1'b1, "min_vs_min"};
        vecs[6] = '{32'h8000_0000,  32'h7FFF_FFFF,  1'b0, 1'b0, "min_vs_max"};
        vecs[7] = '{32'h0000_0001,  32'h0000_0002,  1'b0, 1'b0, "1_vs_2"};
        vecs[8] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, 1'b0, "m2_vs_m1"};

        rst = 1'b1;
        iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;
        iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready1", {31'd0, ir1}, 32'd1);
        chk("reset_out_valid1", {31'd0, ov1}, 32'd0);
        chk("reset_ge1", {31'd0, ge1}, 32'd0);
        chk("reset_in_ready4", {31'd0, ir4}, 32'd1);
        chk("reset_out_valid4", {31'd0, ov4}, 32'd0);
`ifdef COMPARATOR_SERIAL_EQ_OUT_EN
        chk("reset_eq1", {31'd0, eq1}, 32'd0);
`endif
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) xact1(vecs[i].a, vecs[i].b, vecs[i].ge, vecs[i].eq, vecs[i].name);

        // Consumer stalls for 10 cycles while the producer holds the next pair.
        a1 = 32'd10; b1 = 32'd20; iv1 = 1'b1; or1 = 1'b0;
        @(posedge clk);
        e.ge = 1'b0; e.eq = 1'b0;
        q1.push_back(e);
        #1;
        iv1 = 1'b0;
        wait_out1(lat);
        chk("stall_latency", lat, 32'd32);
        a1 = 32'd3; b1 = 32'd2; iv1 = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("stall_out_valid", {31'd0, ov1}, 32'd1);
            chk("stall_ge", {31'd0, ge1}, 32'd0);
            chk("stall_in_ready", {31'd0, ir1}, 32'd0);
        end
        $display("xact stall a=0000000a b=00000014 ge=%b latency=%0d", ge1, lat);
        pop_cmp1("stall");
        or1 = 1'b1;
        @(posedge clk); #1;
        chk("stall_idle_in_ready", {31'd0, ir1}, 32'd1);
        chk("stall_idle_out_valid", {31'd0, ov1}, 32'd0);
        @(posedge clk);
        e.ge = 1'b1; e.eq = 1'b0;
        q1.push_back(e);
        #1;
        iv1 = 1'b0;
        chk("b2b_accepted", {31'd0, ir1}, 32'd0);
        wait_out1(lat);
        chk("b2b_latency", lat, 32'd32);
        $display("xact b2b a=00000003 b=00000002 ge=%b latency=%0d", ge1, lat);
        pop_cmp1("b2b");
        @(posedge clk); #1;

        // Reset in the middle of RUN discards the partial result.
        a1 = 32'd100; b1 = 32'd50; iv1 = 1'b1; or1 = 1'b1;
        @(posedge clk);
        e.ge = 1'b1; e.eq = 1'b0;
        q1.push_back(e);
        #1;
        iv1 = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, ov1}, 32'd0);
        chk("abort_in_ready", {31'd0, ir1}, 32'd1);
        chk("abort_ge", {31'd0, ge1}, 32'd0);
        $display("xact abort a=00000064 b=00000032 discarded");
        q1.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        xact1(32'd3, 32'd2, 1'b1, 1'b0, "after_abort");

        // STEP=4 random pairs against the language's own signed comparison.
        for (int n = 0; n < 1000; n++) begin
            av = $urandom;
            bv = (n % 8 == 0) ? av : ((n % 8 == 1) ? (av ^ 32'h8000_0000) : $urandom);
            chk("s4_in_ready", {31'd0, ir4}, 32'd1);
            a4 = av; b4 = bv; iv4 = 1'b1; or4 = 1'b1;
            @(posedge clk);
            e.ge = ($signed(av) >= $signed(bv));
            e.eq = (av == bv);
            q4.push_back(e);
            #1;
            iv4 = 1'b0; a4 = bv; b4 = av;
            wait_out4(lat);
            chk("s4_latency", lat, 32'd8);
            $display("xact s4_%0d a=%h b=%h ge=%b latency=%0d", n, av, bv, ge4, lat);
            pop_cmp4("s4");
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
